// File: rtl/fmeasurement_gated_pkg.sv
// Shared definitions for the gated frequency meter: FSM state encoding and
// the divided-clock tap positions.
package fmeasurement_gated_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2
    } state_e;

    // Divider bit tapped for each div_select code (00/01/10/11).
    localparam logic [2:0] DIV_TAP_0 = 3'd1;
    localparam logic [2:0] DIV_TAP_1 = 3'd3;
    localparam logic [2:0] DIV_TAP_2 = 3'd5;
    localparam logic [2:0] DIV_TAP_3 = 3'd7;

    // Maps a div_select code to the divider bit index.
    function automatic logic [2:0] div_tap(input logic [1:0] sel);
        logic [2:0] tap;
        case (sel)
            2'b00:   tap = DIV_TAP_0;
            2'b01:   tap = DIV_TAP_1;
            2'b10:   tap = DIV_TAP_2;
            default: tap = DIV_TAP_3;
        endcase
        return tap;
    endfunction

endpackage

// File: rtl/fmeasurement_gated_if.sv
// Result channel of the frequency meter: latched count, flags and the
// valid/ready handshake towards the readout logic.
interface fmeasurement_gated_if #(
    parameter int LENGTH = 24
);
    logic [LENGTH-1:0] result;
    logic              result_overflow;
    logic              result_valid;
    logic              result_ready;
    logic              result_lost;

    // Meter side: produces results, observes ready.
    modport master (
        output result, result_overflow, result_valid, result_lost,
        input  result_ready
    );

    // Readout side: consumes results, drives ready.
    modport slave (
        input  result, result_overflow, result_valid, result_lost,
        output result_ready
    );
endinterface

// File: rtl/fmeasurement_gated_ref_edge_sync.sv
// Reference-pulse front end: optional synchroniser into the measured clock
// domain followed by a rising-edge detector.
module ref_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ref_i,
    input  logic sync_select_i,
    output logic edge_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ref_d_q;
    logic                   ref_f;

    // Shift the asynchronous reference through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ref_i};
        end
    end

    // Select raw or synchronised reference.
    always_comb begin
        ref_f = sync_select_i ? sync_q[SYNC_STAGES-1] : ref_i;
    end

    // Delay the selected reference by one cycle for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_d_q <= 1'b0;
        end else begin
            ref_d_q <= ref_f;
        end
    end

    assign edge_o = ref_f & ~ref_d_q;

endmodule

// File: rtl/fmeasurement_gated.sv
// Gated frequency meter: counts clk cycles over a programmable number of
// reference periods, single-shot or continuous, with a saturating counter,
// a valid/ready result register and a free-running divided debug clock.
module fmeasurement_gated
    import fmeasurement_gated_pkg::*;
#(
    parameter int LENGTH      = 24,
    parameter int GATE_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              continuous,
    input  logic              sync_select,
    input  logic [GATE_W-1:0] gate_periods,
    input  logic              ref_in,
    input  logic [1:0]        div_select,
    fmeasurement_gated_if.master res_if,
    output logic              busy,
    output logic              divided_clk
);
    localparam logic [LENGTH-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [LENGTH-1:0] cnt_q, cnt_d;
    logic [GATE_W-1:0] per_q, per_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic              ovf_q, ovf_d;
    logic              single_done_q, single_done_d;
    logic              enable_q;
    logic [LENGTH-1:0] result_q, result_d;
    logic              result_ovf_q, result_ovf_d;
    logic              valid_q, valid_d;
    logic              lost_q, lost_d;
    logic [7:0]        divcnt_q;

    logic              ref_edge;
    logic              complete;
    logic              cnt_sat;
    logic [LENGTH-1:0] cnt_inc;
    logic [GATE_W-1:0] gate_tgt;

    ref_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ref_edge_sync (
        .clk          (clk),
        .reset        (reset),
        .ref_i        (ref_in),
        .sync_select_i(sync_select),
        .edge_o       (ref_edge)
    );

    // Saturating increment and the effective gate length (0 behaves as 1).
    assign cnt_sat  = (cnt_q == CNT_MAX);
    assign cnt_inc  = cnt_sat ? CNT_MAX : cnt_q + LENGTH'(1);
    assign gate_tgt = (gate_q == '0) ? GATE_W'(1) : gate_q;

    // Next-state logic for the FSM, counters and result register.
    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a latch behind.
        state_d       = state_q;
        cnt_d         = cnt_q;
        per_d         = per_q;
        gate_d        = gate_q;
        ovf_d         = ovf_q;
        single_done_d = single_done_q;
        result_d      = result_q;
        result_ovf_d  = result_ovf_q;
        valid_d       = valid_q;
        lost_d        = lost_q;
        complete      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && (continuous || !single_done_q)) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (ref_edge) begin
                    state_d = ST_COUNT;
                    cnt_d   = LENGTH'(1);
                    per_d   = GATE_W'(1);
                    ovf_d   = 1'b0;
                    gate_d  = gate_periods;
                end
            end
            ST_COUNT: begin
                if (ref_edge && (per_q == gate_tgt)) begin
                    complete = 1'b1;
                    if (continuous) begin
                        cnt_d  = LENGTH'(1);
                        per_d  = GATE_W'(1);
                        ovf_d  = 1'b0;
                        gate_d = gate_periods;
                    end else begin
                        state_d       = ST_IDLE;
                        single_done_d = 1'b1;
                    end
                end else begin
                    // Intermediate edges and idle cycles both advance the count.
                    cnt_d = cnt_inc;
                    if (cnt_sat) begin
                        ovf_d = 1'b1;
                    end
                    if (ref_edge) begin
                        per_d = per_q + GATE_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping enable aborts any gate in progress; the result is kept.
        if (!enable) begin
            state_d       = ST_IDLE;
            single_done_d = 1'b0;
            complete      = 1'b0;
        end

        if (complete) begin
            result_d     = cnt_q;
            result_ovf_d = ovf_q;
            valid_d      = 1'b1;
            if (valid_q && !res_if.result_ready) begin
                lost_d = 1'b1;
            end
        end else if (valid_q && res_if.result_ready) begin
            valid_d = 1'b0;
        end

        if (enable && !enable_q) begin
            lost_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            per_q         <= '0;
            gate_q        <= '0;
            ovf_q         <= 1'b0;
            single_done_q <= 1'b0;
            enable_q      <= 1'b0;
            result_q      <= '0;
            result_ovf_q  <= 1'b0;
            valid_q       <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            per_q         <= per_d;
            gate_q        <= gate_d;
            ovf_q         <= ovf_d;
            single_done_q <= single_done_d;
            enable_q      <= enable;
            result_q      <= result_d;
            result_ovf_q  <= result_ovf_d;
            valid_q       <= valid_d;
            lost_q        <= lost_d;
        end
    end

    // Free-running divider for the debug clock, independent of enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divcnt_q <= '0;
        end else begin
            divcnt_q <= divcnt_q + 8'd1;
        end
    end

    assign divided_clk            = ~divcnt_q[div_tap(div_select)];
    assign busy                   = (state_q == ST_ARM) || (state_q == ST_COUNT);
    assign res_if.result          = result_q;
    assign res_if.result_overflow = result_ovf_q;
    assign res_if.result_valid    = valid_q;
    assign res_if.result_lost     = lost_q;

endmodule

// File: tb/tb_fmeasurement_gated.sv
// Self-checking bench for fmeasurement_gated: a 24-bit and an 8-bit instance
// share all stimulus so wide counts and saturation are checked side by side.
module tb_fmeasurement_gated;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       continuous = 1'b0;
    logic       sync_select = 1'b1;
    logic       ref_in = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] gate_periods = 4'd1;
    logic [1:0] div_select = 2'b00;
    logic       busy, busy8, dclk, dclk8;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int ref_period = 0;
    int ref_phase = 0;

    always #5 clk = ~clk;

    fmeasurement_gated_if #(.LENGTH(24)) res_if ();
    fmeasurement_gated_if #(.LENGTH(8))  res8_if ();
    assign res_if.result_ready  = ready;
    assign res8_if.result_ready = ready;

    fmeasurement_gated #(.LENGTH(24), .GATE_W(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .continuous(continuous),
        .sync_select(sync_select), .gate_periods(gate_periods), .ref_in(ref_in),
        .div_select(div_select), .res_if(res_if), .busy(busy), .divided_clk(dclk)
    );

    fmeasurement_gated #(.LENGTH(8), .GATE_W(4), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .continuous(continuous),
        .sync_select(sync_select), .gate_periods(gate_periods), .ref_in(ref_in),
        .div_select(div_select), .res_if(res8_if), .busy(busy8), .divided_clk(dclk8)
    );

    typedef struct {
        int         period;
        logic [3:0] gate;
        logic       ssel;
        int         exp24;
        int         exp8;
        logic       ovf8;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: advance to the falling edge, then drive the reference pulse train.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ref_period == 0) begin
            ref_in = 1'b0;
        end else begin
            ref_in = (ref_phase == 0);
            ref_phase = (ref_phase + 1 == ref_period) ? 0 : ref_phase + 1;
        end
    endtask

    // Stop the FSM, silence the reference, drain any pending result.
    task automatic quiesce();
        enable = 1'b0;
        ref_period = 0;
        ready = 1'b1;
        repeat (6) tick();
        ready = 1'b0;
        tick();
    endtask

    task automatic wait_valid(input int budget, input string name, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (res_if.result_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no result_valid within %0d cycles", name, budget);
        end
    endtask

    // Single-shot measurement compared against N*P, saturated for the 8-bit meter.
    task automatic measure_single(input int period, input logic [3:0] gate, input logic ssel,
                                  input bit scramble, input string name);
        int      eff;
        longint  exp;
        int      budget;
        bit      ok;
        eff = (gate == 4'd0) ? 1 : int'(gate);
        exp = longint'(eff) * period;
        quiesce();
        gate_periods = gate;
        sync_select  = ssel;
        continuous   = 1'b0;
        ref_period   = period;
        ref_phase    = 0;
        enable       = 1'b1;
        budget       = (eff + 3) * period + 50;
        ok           = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (scramble && c == period + 10) gate_periods = 4'($urandom);
            if (res_if.result_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no result_valid within %0d cycles", name, budget);
        end else begin
            check({name, ".result"},   64'(res_if.result), 64'(exp));
            check({name, ".ovf"},      64'(res_if.result_overflow), 64'd0);
            check({name, ".busy"},     64'(busy), 64'd0);
            check({name, ".result8"},  64'(res8_if.result), 64'((exp > 255) ? 255 : exp));
            check({name, ".ovf8"},     64'(res8_if.result_overflow), 64'(exp > 255));
            check({name, ".valid8"},   64'(res8_if.result_valid), 64'd1);
        end
    endtask

    initial begin
        bit ok;
        int prev_cyc;
        int first, per;
        logic prev;

        vecs[0] = '{1000, 4'd1, 1'b1, 1000, 255, 1'b1};
        vecs[1] = '{250,  4'd4, 1'b1, 1000, 255, 1'b1};
        vecs[2] = '{100,  4'd0, 1'b0, 100,  100, 1'b0};
        vecs[3] = '{50,   4'd3, 1'b0, 150,  150, 1'b0};
        vecs[4] = '{85,   4'd3, 1'b1, 255,  255, 1'b0};
        vecs[5] = '{64,   4'd4, 1'b1, 256,  255, 1'b1};
        vecs[6] = '{300,  4'd1, 1'b1, 300,  255, 1'b1};
        vecs[7] = '{100,  4'd1, 1'b1, 100,  100, 1'b0};

        // Reset values while reset is held.
        repeat (3) tick();
        check("rst.result", 64'(res_if.result), 64'd0);
        check("rst.valid",  64'(res_if.result_valid), 64'd0);
        check("rst.lost",   64'(res_if.result_lost), 64'd0);
        check("rst.ovf",    64'(res_if.result_overflow), 64'd0);
        check("rst.busy",   64'(busy), 64'd0);
        check("rst.dclk",   64'(dclk), 64'd1);
        reset = 1'b0;
        tick();

        // Table-driven single-shot gates; the table's expectations are hand-derived.
        for (int i = 0; i < 8; i++) begin
            measure_single(vecs[i].period, vecs[i].gate, vecs[i].ssel, 1'b0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.tab24", i), 64'(res_if.result), 64'(vecs[i].exp24));
            check($sformatf("vec%0d.tab8", i),  64'(res8_if.result), 64'(vecs[i].exp8));
            check($sformatf("vec%0d.tabovf8", i), 64'(res8_if.result_overflow), 64'(vecs[i].ovf8));
        end

        // Randomised gates against the N*P model, with gate_periods disturbed mid-gate.
        for (int r = 0; r < 6; r++) begin
            measure_single(int'($urandom_range(150, 20)), 4'($urandom), 1'($urandom), 1'b1,
                           $sformatf("rnd%0d", r));
        end

        // Continuous, 4 periods of 250: one result every 1000 cycles, nothing lost.
        quiesce();
        continuous = 1'b1; gate_periods = 4'd4; sync_select = 1'b1;
        ready = 1'b1; ref_period = 250; ref_phase = 0; enable = 1'b1;
        prev_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_valid(1300, "cont.wait", ok);
            if (!ok) break;
            check("cont.result", 64'(res_if.result), 64'd1000);
            check("cont.lost",   64'(res_if.result_lost), 64'd0);
            if (k > 0) check("cont.spacing", 64'(cyc - prev_cyc), 64'd1000);
            prev_cyc = cyc;
            tick();
            check("cont.vfall", 64'(res_if.result_valid), 64'd0);
        end

        // Lost result: second completion with nobody accepting.
        quiesce();
        continuous = 1'b1; gate_periods = 4'd1; ref_period = 100; ref_phase = 0; enable = 1'b1;
        wait_valid(300, "lost.wait", ok);
        check("lost.first_lost", 64'(res_if.result_lost), 64'd0);
        repeat (100) tick();
        check("lost.result", 64'(res_if.result), 64'd100);
        check("lost.valid",  64'(res_if.result_valid), 64'd1);
        check("lost.lost",   64'(res_if.result_lost), 64'd1);

        // Abort 60 cycles after enable (well into COUNT); pending result must survive.
        enable = 1'b0; ref_period = 0;
        repeat (6) tick();
        continuous = 1'b0; ref_period = 200; ref_phase = 0; enable = 1'b1;
        tick();
        check("abort.lost_clr", 64'(res_if.result_lost), 64'd0);
        repeat (60) tick();
        check("abort.busy_pre", 64'(busy), 64'd1);
        enable = 1'b0;
        tick();
        check("abort.busy",   64'(busy), 64'd0);
        check("abort.result", 64'(res_if.result), 64'd100);
        check("abort.valid",  64'(res_if.result_valid), 64'd1);
        check("abort.lost",   64'(res_if.result_lost), 64'd0);
        quiesce();
        ref_period = 200; ref_phase = 0; enable = 1'b1;
        wait_valid(500, "abort.remeasure", ok);
        check("abort.re_result", 64'(res_if.result), 64'd200);
        check("abort.re_lost",   64'(res_if.result_lost), 64'd0);

        // Completion coinciding with accept: new result kept, no loss.
        quiesce();
        continuous = 1'b1; gate_periods = 4'd1; ref_period = 100; ref_phase = 0; enable = 1'b1;
        wait_valid(300, "same.wait", ok);
        repeat (99) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("same.valid",  64'(res_if.result_valid), 64'd1);
        check("same.lost",   64'(res_if.result_lost), 64'd0);
        check("same.result", 64'(res_if.result), 64'd100);

        // Asynchronous reset mid-COUNT, observed before the next rising edge.
        repeat (30) tick();
        check("areset.busy_pre", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("areset.result", 64'(res_if.result), 64'd0);
        check("areset.ovf",    64'(res_if.result_overflow), 64'd0);
        check("areset.valid",  64'(res_if.result_valid), 64'd0);
        check("areset.lost",   64'(res_if.result_lost), 64'd0);
        check("areset.busy",   64'(busy), 64'd0);
        check("areset.dclk",   64'(dclk), 64'd1);
        tick();
        reset = 1'b0;
        enable = 1'b0;
        ref_period = 0;

        // Divided clock period for every tap: 2^(tap+1) cycles.
        for (int s = 0; s < 4; s++) begin
            div_select = 2'(s);
            tick();
            prev  = dclk;
            first = -1;
            per   = -1;
            for (int c = 0; c < 1000; c++) begin
                tick();
                if (!prev && dclk) begin
                    if (first < 0) begin
                        first = cyc;
                    end else begin
                        per = cyc - first;
                        break;
                    end
                end
                prev = dclk;
            end
            check($sformatf("div.period%0d", s), 64'(per), 64'(1 << (2 * s + 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
